mem_access_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port 2K x 16 scratch memory between NUM_REQ requesters, such as the test generator and the neural-engine compute units. It accepts one access at a time and drives the memory strobes (address, data, wr_en, rd_en, chip_sel). Read data is returned to the originating requester after the memory's fixed read latency. The block sits between the requesters and the memory macro and is the only driver of the memory interface.

---
 rtl/mem_access_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Round-robin arbiter sharing one single-port scratch memory between
//   NUM_REQ requesters. One access is accepted per two cycles: an ARB cycle
//   picks the winner, the following ACCESS cycle drives the registered
//   memory strobes and the one-hot gnt pulse. Read returns are routed back
//   to the originating requester RD_LATENCY cycles after the rd_en cycle.
//
//   Optional build macro MEM_ARB_LOCK_EN: adds req_lock; a locked winner
//   keeps top priority and chip_sel stays high between its accesses.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req/req_we                    per-requester request and write select
//   req_addr/req_wdata            packed per-requester address / write data
//   req_lock (MEM_ARB_LOCK_EN)    per-requester burst lock
//   gnt                           one-hot accept pulse (ACCESS cycle)
//   rd_valid/rd_data              one-hot read-return pulse and its data
//   mem_address/mem_data_out      memory address / write data
//   mem_wr_en/mem_rd_en           memory write / read strobes
//   mem_chip_sel                  memory select
//   mem_rdata                     memory read data
module mem_access_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data_out,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic                      mem_chip_sel,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ARB, ACCESS} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     wid_q, wid_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic               cs_q, cs_d;
  logic [DATA_W-1:0]  rd_data_q;
`ifdef MEM_ARB_LOCK_EN
  logic               lock_q, lock_d;
`endif

  // Read-return pipeline: stage RD_LATENCY-1 lines up with mem_rdata.
  logic               pipe_vld_q [RD_LATENCY];
  logic [IDW-1:0]     pipe_id_q  [RD_LATENCY];

  logic               found;
  logic [IDW-1:0]     win;
  int                 idx;
  logic [IDW-1:0]     idx_b;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_b = '0;
    // Search upward from the pointer, wrapping modulo NUM_REQ.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_b = IDW'(idx);
      if (!found && req[idx_b]) begin
        found = 1'b1;
        win   = idx_b;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wid_d   = wid_q;
    gnt_d   = '0;
    addr_d  = '0;
    wdata_d = '0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    cs_d    = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      ARB: begin
        if (found) begin
          addr_d     = req_addr[win*ADDR_W +: ADDR_W];
          wdata_d    = req_wdata[win*DATA_W +: DATA_W];
          wr_d       = req_we[win];
          rd_d       = !req_we[win];
          cs_d       = 1'b1;
          gnt_d[win] = 1'b1;
          wid_d      = win;
          ptr_d      = next_id(win);
          state_d    = ACCESS;
`ifdef MEM_ARB_LOCK_EN
          lock_d = req_lock[win];
          if (req_lock[win]) ptr_d = win;
        end else begin
          lock_d = 1'b0;
`endif
        end
      end
      default: begin
        // ACCESS: strobes are live this cycle; req is not looked at
        // except to see whether a burst lock is still held.
        state_d = ARB;
`ifdef MEM_ARB_LOCK_EN
        if (lock_q) begin
          if (req[wid_q] && req_lock[wid_q]) cs_d = 1'b1;
          else                               ptr_d = next_id(wid_q);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      wid_q     <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cs_q      <= 1'b0;
      rd_data_q <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_q    <= 1'b0;
`endif
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_id_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wid_q   <= wid_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cs_q    <= cs_d;
`ifdef MEM_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
      // rd_q is only ever high in ACCESS, so it marks the read strobe cycle.
      pipe_vld_q[0] <= rd_q;
      pipe_id_q[0]  <= wid_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
      if (pipe_vld_q[RD_LATENCY-1]) rd_data_q <= mem_rdata;
    end
  end

  always_comb begin
    rd_valid = '0;
    if (pipe_vld_q[RD_LATENCY-1]) rd_valid[pipe_id_q[RD_LATENCY-1]] = 1'b1;
  end

  // Return data comes straight from the memory in the return cycle and is
  // held afterwards.
  assign rd_data      = pipe_vld_q[RD_LATENCY-1] ? mem_rdata : rd_data_q;
  assign gnt          = gnt_q;
  assign mem_address  = addr_q;
  assign mem_data_out = wdata_q;
  assign mem_wr_en    = wr_q;
  assign mem_rd_en    = rd_q;
  assign mem_chip_sel = cs_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter (NUM_REQ=2, RD_LATENCY=3).
// Expected accesses and read returns are queued when stimulus is issued and
// matched against the DUT outputs by a negedge monitor.
module tb_mem_access_arbiter;
  localparam int RDL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, req_we;
  logic [21:0] req_addr;
  logic [31:0] req_wdata;
`ifdef MEM_ARB_LOCK_EN
  logic [1:0]  req_lock;
`endif
  logic [1:0]  gnt, rd_valid;
  logic [15:0] rd_data, mem_data_out, mem_rdata;
  logic [10:0] mem_address;
  logic        mem_wr_en, mem_rd_en, mem_chip_sel;

  always #5 clk = ~clk;

  mem_access_arbiter #(.NUM_REQ(2), .ADDR_W(11), .DATA_W(16), .RD_LATENCY(RDL)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_chip_sel(mem_chip_sel), .mem_rdata(mem_rdata)
  );

  // Memory model: unwritten words read as addr ^ 0xA5A5, RDL-cycle latency.
  logic [15:0] mem [2048];
  bit          written [2048];
  logic [15:0] rpipe [RDL];
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_address]     <= mem_data_out;
      written[mem_address] <= 1'b1;
    end
    rpipe[0] <= written[mem_address] ? mem[mem_address] : ({5'b0, mem_address} ^ 16'hA5A5);
    for (int i = 1; i < RDL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RDL-1];

  typedef struct {logic we; logic [10:0] addr; logic [15:0] data;} op_t;
  typedef struct {logic [1:0] g; logic we; logic [10:0] addr; logic [15:0] data;} acc_t;
  typedef struct {logic [1:0] v; logic [15:0] data;} rd_t;

  op_t  ops0[$], ops1[$];
  acc_t exp_acc[$];
  rd_t  exp_rd[$];
  int   due[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, last_g = -1, g1_cnt = 0, mon_g1 = 0;
  bit   gap_chk = 0, lock_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [15:0] rd_model(input logic [10:0] a);
    return {5'b0, a} ^ 16'hA5A5;
  endfunction

  // Queue an expected access in grant order; reads also queue their return.
  task automatic expect_acc(input logic [1:0] g, input logic we, input logic [10:0] a,
                            input logic [15:0] d);
    acc_t e;
    rd_t  r;
    e.g = g; e.we = we; e.addr = a; e.data = d;
    exp_acc.push_back(e);
    if (!we) begin
      r.v = g; r.data = d;
      exp_rd.push_back(r);
    end
  endtask

  task automatic add_op(input int id, input logic we, input logic [10:0] a, input logic [15:0] d);
    op_t o;
    o.we = we; o.addr = a; o.data = d;
    if (id == 0) ops0.push_back(o);
    else         ops1.push_back(o);
  endtask

  task automatic drive_reqs();
    req = {ops1.size() > 0, ops0.size() > 0};
    req_we = '0; req_addr = '0; req_wdata = '0;
    if (ops0.size() > 0) begin
      req_we[0] = ops0[0].we; req_addr[10:0] = ops0[0].addr; req_wdata[15:0] = ops0[0].data;
    end
    if (ops1.size() > 0) begin
      req_we[1] = ops1[0].we; req_addr[21:11] = ops1[0].addr; req_wdata[31:16] = ops1[0].data;
    end
`ifdef MEM_ARB_LOCK_EN
    req_lock = {lock_mode && (ops1.size() > 0) && (g1_cnt < 4), 1'b0};
`endif
  endtask

  // One clock: requesters advance to their next op once gnt is seen.
  task automatic step();
    @(posedge clk); #1;
    if (gnt[0] && ops0.size() > 0) void'(ops0.pop_front());
    if (gnt[1] && ops1.size() > 0) begin
      void'(ops1.pop_front());
      g1_cnt++;
    end
    drive_reqs();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    ops0.delete(); ops1.delete();
    g1_cnt = 0;
    drive_reqs();
    step(); step();
    exp_acc.delete(); exp_rd.delete(); due.delete();
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (ops0.size() == 0 && ops1.size() == 0 && exp_acc.size() == 0 &&
          due.size() == 0 && exp_rd.size() == 0) begin
        ok = 1;
        break;
      end
      step();
    end
    check_eq({tag, "_complete"}, 32'(ok), 32'd1);
  endtask

  // Monitor: checks grants against the access queue and read returns
  // against the return queue, sampled on the falling edge.
  always @(negedge clk) begin
    acc_t e;
    rd_t  r;
    if (!reset) begin
      check_eq("wr_rd_exclusive", 32'(mem_wr_en & mem_rd_en), 32'd0);
      if (gnt != 2'b00) begin
        if (exp_acc.size() == 0) check_eq("gnt_unexpected", 32'(gnt), 32'd0);
        else begin
          e = exp_acc.pop_front();
          check_eq("gnt", 32'(gnt), 32'(e.g));
          check_eq("mem_address", 32'(mem_address), 32'(e.addr));
          check_eq("mem_wr_en", 32'(mem_wr_en), 32'(e.we));
          check_eq("mem_rd_en", 32'(mem_rd_en), 32'(!e.we));
          check_eq("mem_chip_sel", 32'(mem_chip_sel), 32'd1);
          if (e.we) check_eq("mem_data_out", 32'(mem_data_out), 32'(e.data));
        end
        if (gap_chk && last_g >= 0) check_eq("gnt_gap", 32'(cyc - last_g), 32'd2);
        last_g = cyc;
        if (mem_rd_en) due.push_back(cyc + RDL);
        if (gnt[1]) mon_g1++;
      end else begin
        check_eq("idle_strobes", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        if (!lock_mode) check_eq("idle_chip_sel", 32'(mem_chip_sel), 32'd0);
        else if (mon_g1 >= 1 && mon_g1 <= 3) check_eq("lock_chip_sel_hold", 32'(mem_chip_sel), 32'd1);
      end
      if (due.size() > 0 && due[0] == cyc) begin
        void'(due.pop_front());
        if (exp_rd.size() == 0) check_eq("rd_unexpected", 32'(rd_valid), 32'd0);
        else begin
          r = exp_rd.pop_front();
          check_eq("rd_valid", 32'(rd_valid), 32'(r.v));
          check_eq("rd_data", 32'(rd_data), 32'(r.data));
        end
      end else begin
        check_eq("rd_valid_spurious", 32'(rd_valid), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1;
    drive_reqs();
    apply_reset();
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_address", 32'(mem_address), 32'd0);
    check_eq("rst_data_out", 32'(mem_data_out), 32'd0);
    check_eq("rst_strobes", 32'({mem_wr_en, mem_rd_en, mem_chip_sel}), 32'd0);

    // Single write from requester 0.
    add_op(0, 1'b1, 11'h005, 16'hBEEF);
    expect_acc(2'b01, 1'b1, 11'h005, 16'hBEEF);
    drive_reqs();
    wait_done("t1");
    step();
    check_eq("t1_after_addr", 32'(mem_address), 32'd0);
    check_eq("t1_after_data", 32'(mem_data_out), 32'd0);
    check_eq("t1_after_gnt", 32'(gnt), 32'd0);

    // Both requesters reading back-to-back: alternating grants every 2 cycles.
    apply_reset();
    gap_chk = 1; last_g = -1;
    for (int k = 0; k < 4; k++) begin
      add_op(0, 1'b0, 11'(11'h010 + k), 16'h0);
      add_op(1, 1'b0, 11'(11'h020 + k), 16'h0);
      expect_acc(2'b01, 1'b0, 11'(11'h010 + k), rd_model(11'(11'h010 + k)));
      expect_acc(2'b10, 1'b0, 11'(11'h020 + k), rd_model(11'(11'h020 + k)));
    end
    drive_reqs();
    wait_done("t2");
    gap_chk = 0;

    // Write then read the top address from requester 1.
    apply_reset();
    add_op(1, 1'b1, 11'h7FF, 16'h1234);
    add_op(1, 1'b0, 11'h7FF, 16'h0);
    expect_acc(2'b10, 1'b1, 11'h7FF, 16'h1234);
    expect_acc(2'b10, 1'b0, 11'h7FF, 16'h1234);
    drive_reqs();
    wait_done("t3");

    // Reset during the ACCESS of a read while another read is in flight.
    apply_reset();
    add_op(0, 1'b0, 11'h100, 16'h0);
    add_op(1, 1'b0, 11'h101, 16'h0);
    expect_acc(2'b01, 1'b0, 11'h100, rd_model(11'h100));
    expect_acc(2'b10, 1'b0, 11'h101, rd_model(11'h101));
    drive_reqs();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt == 2'b10) begin
        seen = 1;
        break;
      end
    end
    check_eq("t4_reached_access", 32'(seen), 32'd1);
    reset = 1'b1;
    ops0.delete(); ops1.delete();
    drive_reqs();
    @(posedge clk); #1;
    check_eq("t4_abort_strobes", 32'({mem_wr_en, mem_rd_en, mem_chip_sel}), 32'd0);
    check_eq("t4_abort_gnt", 32'(gnt), 32'd0);
    check_eq("t4_abort_rd_valid", 32'(rd_valid), 32'd0);
    exp_acc.delete(); exp_rd.delete(); due.delete();
    reset = 1'b0;
    repeat (RDL + 5) step();
    add_op(0, 1'b0, 11'h102, 16'h0);
    add_op(1, 1'b0, 11'h103, 16'h0);
    expect_acc(2'b01, 1'b0, 11'h102, rd_model(11'h102));
    expect_acc(2'b10, 1'b0, 11'h103, rd_model(11'h103));
    drive_reqs();
    wait_done("t4");

    // Idle bus, then both request: requester 0 first.
    apply_reset();
    repeat (10) step();
    add_op(0, 1'b1, 11'h200, 16'h00A0);
    add_op(1, 1'b1, 11'h201, 16'h00A1);
    expect_acc(2'b01, 1'b1, 11'h200, 16'h00A0);
    expect_acc(2'b10, 1'b1, 11'h201, 16'h00A1);
    drive_reqs();
    wait_done("t5");

`ifdef MEM_ARB_LOCK_EN
    // Locked burst from requester 1, then lock released.
    apply_reset();
    lock_mode = 1; mon_g1 = 0;
    for (int k = 0; k < 4; k++)
      expect_acc(2'b10, 1'b0, 11'(11'h300 + k), rd_model(11'(11'h300 + k)));
    expect_acc(2'b01, 1'b1, 11'h310, 16'h5A5A);
    expect_acc(2'b10, 1'b0, 11'h304, rd_model(11'h304));
    for (int k = 0; k < 5; k++) add_op(1, 1'b0, 11'(11'h300 + k), 16'h0);
    drive_reqs();
    step();
    add_op(0, 1'b1, 11'h310, 16'h5A5A);
    drive_reqs();
    wait_done("t6");
    lock_mode = 0;
`endif

    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
